operand_skew_feeder: RTL and testbench

OPERAND_SKEW_FEEDER -- requirements
Module: operand_skew_feeder

---
 rtl/common_pkg.sv | 32 +++
 rtl/skew_delay_line.sv | 31 +++
 rtl/operand_skew_feeder.sv | 137 +++++++++++++
 tb/tb_operand_skew_feeder.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/common_pkg.sv
// Shared types and sizing for the systolic-array operand path.
package common_pkg;

    localparam int DATA_W         = 8;
    localparam int SYS_ARRAY_SIZE = 4;
    localparam int T_C            = 4;

    typedef logic signed [DATA_W-1:0] data_t;

    // One element on an array edge lane, tagged with end-of-tile.
    typedef struct packed {
        logic  last;
        data_t data;
    } matrix_data_t;

    // Load/stream counter: indexes a tile of up to T_C vectors.
    localparam int MCOUNT_W = (T_C > 1) ? $clog2(T_C) : 1;
    typedef logic [MCOUNT_W-1:0] mcount_t;

    // Flush counter: counts up to SYS_ARRAY_SIZE drain cycles.
    localparam int FCOUNT_W = (SYS_ARRAY_SIZE > 1) ? $clog2(SYS_ARRAY_SIZE) : 1;
    typedef logic [FCOUNT_W-1:0] fcount_t;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        WAIT,
        STREAM,
        FLUSH
    } feeder_state_e;

endpackage

// File: rtl/skew_delay_line.sv
// Fixed-length register chain that delays one lane element by LEN cycles.
module skew_delay_line
    import common_pkg::*;
#(
    parameter int LEN = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  matrix_data_t din,
    output matrix_data_t dout
);

    matrix_data_t stage_p [LEN];

    // Shift the element one stage per cycle; reset drains the whole chain to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < LEN; j++) begin
                stage_p[j] <= '0;
            end
        end else begin
            stage_p[0] <= din;
            for (int j = 1; j < LEN; j++) begin
                stage_p[j] <= stage_p[j-1];
            end
        end
    end

    assign dout = stage_p[LEN-1];

endmodule

// File: rtl/operand_skew_feeder.sv
// Buffers one operand tile, then streams it into the array edge with a
// per-lane skew so lane i lags lane 0 by i cycles.
// DEPTH must not exceed T_C and N must not exceed SYS_ARRAY_SIZE, since the
// counters are sized from those package constants.
module operand_skew_feeder
    import common_pkg::*;
#(
    parameter int N     = SYS_ARRAY_SIZE,
    parameter int DEPTH = T_C
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic                 mem_valid_i,
    output logic                 mem_ready_o,
    input  data_t [N-1:0]        mem_data_i,
    output logic                 loaded_o,
    input  logic                 go_i,
    output matrix_data_t [N-1:0] feed_o,
    output logic                 busy_o,
    output logic                 done_o
);

    localparam mcount_t LAST_K = mcount_t'(DEPTH - 1);
    localparam fcount_t LAST_F = fcount_t'(N - 1);
    localparam int      IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    feeder_state_e state_q, state_d;
    mcount_t       cnt_q, cnt_d;
    mcount_t       scnt_q, scnt_d;
    fcount_t       fcnt_q, fcnt_d;
    logic          buf_we;

    data_t [N-1:0]        tile_buf [DEPTH];
    matrix_data_t [N-1:0] inj;

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            scnt_q  <= '0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            scnt_q  <= scnt_d;
            fcnt_q  <= fcnt_d;
        end
    end

    // Next-state, counter advance and buffer write enable; counters hold at
    // their terminal value instead of wrapping.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        scnt_d  = scnt_q;
        fcnt_d  = fcnt_q;
        buf_we  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = FILL;
                    cnt_d   = '0;
                end
            end
            FILL: begin
                if (mem_valid_i) begin
                    buf_we = 1'b1;
                    if (cnt_q == LAST_K) begin
                        state_d = WAIT;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            WAIT: begin
                if (go_i) begin
                    state_d = STREAM;
                    scnt_d  = '0;
                end
            end
            STREAM: begin
                if (scnt_q == LAST_K) begin
                    state_d = FLUSH;
                    fcnt_d  = '0;
                end else begin
                    scnt_d = scnt_q + 1'b1;
                end
            end
            FLUSH: begin
                if (fcnt_q == LAST_F) begin
                    state_d = IDLE;
                end else begin
                    fcnt_d = fcnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Tile storage; contents are only read after a full FILL, so no reset.
    always_ff @(posedge clk) begin
        if (buf_we) begin
            tile_buf[cnt_q[IDX_W-1:0]] <= mem_data_i;
        end
    end

    // Lane injection: buffered vector during STREAM, zero bubbles otherwise.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            inj[i] = '0;
            if (state_q == STREAM) begin
                inj[i].data = tile_buf[scnt_q[IDX_W-1:0]][i];
                inj[i].last = (scnt_q == LAST_K);
            end
        end
    end

    // Lane i sits i+1 registers from the injection point.
    for (genvar i = 0; i < N; i++) begin : g_lane
        skew_delay_line #(
            .LEN(i + 1)
        ) u_line (
            .clk (clk),
            .rst (rst),
            .din (inj[i]),
            .dout(feed_o[i])
        );
    end

    assign mem_ready_o = (state_q == FILL);
    assign loaded_o    = (state_q == WAIT);
    assign busy_o      = (state_q != IDLE);
    assign done_o      = (state_q == FLUSH) && (fcnt_q == LAST_F);

endmodule

// File: tb/tb_operand_skew_feeder.sv
// Self-checking bench for operand_skew_feeder (N=2, DEPTH=2).
module tb_operand_skew_feeder;
    import common_pkg::*;

    localparam int N = 2;
    localparam int D = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start_i;
    logic                 mem_valid_i;
    logic                 mem_ready_o;
    data_t [N-1:0]        mem_data_i;
    logic                 loaded_o;
    logic                 go_i;
    matrix_data_t [N-1:0] feed_o;
    logic                 busy_o;
    logic                 done_o;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    data_t tile [D][N];
    int    stall_n [D];

    typedef struct {
        bit start, mv, go;
        int d0, d1;
        bit e_ready, e_loaded, e_busy, e_done;
        int e_f0;
        bit e_l0;
        int e_f1;
        bit e_l1;
    } row_t;

    row_t tbl [9];

    always #5 clk = ~clk;

    operand_skew_feeder #(.N(N), .DEPTH(D)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .mem_valid_i(mem_valid_i),
        .mem_ready_o(mem_ready_o),
        .mem_data_i (mem_data_i),
        .loaded_o   (loaded_o),
        .go_i       (go_i),
        .feed_o     (feed_o),
        .busy_o     (busy_o),
        .done_o     (done_o)
    );

    function automatic row_t mk(bit s, bit mv, bit g, int d0, int d1,
                                bit er, bit el, bit eb, bit ed,
                                int f0, bit l0, int f1, bit l1);
        row_t r;
        r.start = s; r.mv = mv; r.go = g; r.d0 = d0; r.d1 = d1;
        r.e_ready = er; r.e_loaded = el; r.e_busy = eb; r.e_done = ed;
        r.e_f0 = f0; r.e_l0 = l0; r.e_f1 = f1; r.e_l1 = l1;
        return r;
    endfunction

    // Outputs are sampled and inputs changed at the falling edge.
    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic chk(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
        end
    endtask

    task automatic chk_ctrl(input string tag, input bit r, input bit l,
                            input bit b, input bit d);
        chk({tag, "_ready"},  mem_ready_o, r);
        chk({tag, "_loaded"}, loaded_o, l);
        chk({tag, "_busy"},   busy_o, b);
        chk({tag, "_done"},   done_o, d);
    endtask

    task automatic chk_zero(input string tag);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("%s_l%0d_data", tag, i), feed_o[i].data, 0);
            chk($sformatf("%s_l%0d_last", tag, i), feed_o[i].last, 0);
        end
    endtask

    // Load `tile` with stall_n[v] idle cycles before vector v, hold go off for
    // go_dly WAIT cycles, then check the stream against the timing rule:
    // element k of lane i appears j = k+i+2 cycles after the go cycle.
    task automatic run_tile(input int go_dly, input int rst_at,
                            input bit stray, input bit done_start);
        chk_ctrl("idle", 0, 0, 0, 0);
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        for (int v = 0; v < D; v++) begin
            for (int s = 0; s < stall_n[v]; s++) begin
                chk_ctrl("stall", 1, 0, 1, 0);
                chk_zero("stall");
                mem_valid_i = 1'b0;
                go_i        = stray;
                step();
                go_i = 1'b0;
            end
            chk_ctrl("fill", 1, 0, 1, 0);
            chk_zero("fill");
            mem_valid_i = 1'b1;
            for (int i = 0; i < N; i++) mem_data_i[i] = tile[v][i];
            step();
            mem_valid_i = 1'b0;
        end
        for (int d = 0; d < go_dly; d++) begin
            chk_ctrl("hold", 0, 1, 1, 0);
            chk_zero("hold");
            if (stray) begin
                mem_valid_i = 1'b1;
                start_i     = 1'b1;
                for (int i = 0; i < N; i++) mem_data_i[i] = data_t'($urandom_range(0, 255));
            end
            step();
            mem_valid_i = 1'b0;
            start_i     = 1'b0;
        end
        chk_ctrl("wait", 0, 1, 1, 0);
        go_i = 1'b1;
        step();
        go_i = 1'b0;
        for (int j = 1; j <= D + N + 1; j++) begin
            bit alive;
            alive = (rst_at < 0) || (j <= rst_at);
            chk("strm_ready",  mem_ready_o, 0);
            chk("strm_loaded", loaded_o, 0);
            chk("strm_busy",   busy_o, alive && (j <= D + N));
            chk("strm_done",   done_o, alive && (j == D + N));
            for (int i = 0; i < N; i++) begin
                int k;
                logic signed [31:0] ed;
                bit el;
                k  = j - i - 2;
                ed = 0;
                el = 1'b0;
                if (alive && k >= 0 && k < D) begin
                    ed = tile[k][i];
                    el = (k == D - 1);
                end
                chk($sformatf("lane%0d_data", i), feed_o[i].data, ed);
                chk($sformatf("lane%0d_last", i), feed_o[i].last, el);
            end
            rst         = (j == rst_at);
            start_i     = (stray && j == 1) || (done_start && j == D + N);
            mem_valid_i = stray && (j == 1);
            go_i        = stray && (j == 2);
            if (stray) begin
                for (int i = 0; i < N; i++) mem_data_i[i] = data_t'($urandom_range(0, 255));
            end
            step();
        end
        rst         = 1'b0;
        start_i     = 1'b0;
        mem_valid_i = 1'b0;
        go_i        = 1'b0;
    endtask

    task automatic set_fixed_tile();
        tile[0][0] = 1; tile[0][1] = 2;
        tile[1][0] = 3; tile[1][1] = 4;
        stall_n[0] = 0; stall_n[1] = 0;
    endtask

    initial begin
        rst         = 1'b1;
        start_i     = 1'b0;
        mem_valid_i = 1'b0;
        go_i        = 1'b0;
        mem_data_i  = '0;

        tbl[0] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[1] = mk(0, 1, 0, 1, 2, 1, 0, 1, 0, 0, 0, 0, 0);
        tbl[2] = mk(0, 1, 0, 3, 4, 1, 0, 1, 0, 0, 0, 0, 0);
        tbl[3] = mk(0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        tbl[4] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        tbl[5] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
        tbl[6] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 3, 1, 2, 0);
        tbl[7] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 4, 1);
        tbl[8] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset state
        repeat (3) step();
        chk_ctrl("rst", 0, 0, 0, 0);
        chk_zero("rst");
        rst = 1'b0;
        step();
        chk_ctrl("post_rst", 0, 0, 0, 0);

        // Basic back-to-back load, table driven
        for (int r = 0; r < 9; r++) begin
            chk("tbl_ready",  mem_ready_o, tbl[r].e_ready);
            chk("tbl_loaded", loaded_o,    tbl[r].e_loaded);
            chk("tbl_busy",   busy_o,      tbl[r].e_busy);
            chk("tbl_done",   done_o,      tbl[r].e_done);
            chk("tbl_f0",     feed_o[0].data, tbl[r].e_f0);
            chk("tbl_l0",     feed_o[0].last, tbl[r].e_l0);
            chk("tbl_f1",     feed_o[1].data, tbl[r].e_f1);
            chk("tbl_l1",     feed_o[1].last, tbl[r].e_l1);
            start_i       = tbl[r].start;
            mem_valid_i   = tbl[r].mv;
            go_i          = tbl[r].go;
            mem_data_i[0] = data_t'(tbl[r].d0);
            mem_data_i[1] = data_t'(tbl[r].d1);
            step();
        end
        start_i     = 1'b0;
        mem_valid_i = 1'b0;
        go_i        = 1'b0;

        // Fill stall between vectors
        set_fixed_tile();
        stall_n[1] = 3;
        run_tile(0, -1, 1'b0, 1'b0);

        // go held off for 5 cycles
        set_fixed_tile();
        run_tile(5, -1, 1'b0, 1'b0);

        // Stray start/mem_valid/go outside their states
        set_fixed_tile();
        run_tile(3, -1, 1'b1, 1'b0);

        // Reset two cycles after go, then a fresh tile
        set_fixed_tile();
        run_tile(0, 2, 1'b0, 1'b0);
        set_fixed_tile();
        run_tile(0, -1, 1'b0, 1'b0);

        // start in the done cycle is ignored; next tile starts one cycle later
        set_fixed_tile();
        tile[0][0] = 5; tile[0][1] = -6; tile[1][0] = 7; tile[1][1] = -8;
        run_tile(0, -1, 1'b0, 1'b1);
        set_fixed_tile();
        run_tile(0, -1, 1'b0, 1'b0);

        // Randomized tiles
        for (int t = 0; t < 40; t++) begin
            int rst_at;
            bit ds;
            for (int k = 0; k < D; k++) begin
                stall_n[k] = $urandom_range(0, 3);
                for (int i = 0; i < N; i++) tile[k][i] = data_t'($urandom_range(0, 255));
            end
            rst_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, D + N)) : -1;
            ds     = (rst_at < 0) && ($urandom_range(0, 1) == 1);
            run_tile($urandom_range(0, 4), rst_at, $urandom_range(0, 1) == 1, ds);
            repeat ($urandom_range(0, 2)) begin
                chk_ctrl("gap", 0, 0, 0, 0);
                chk_zero("gap");
                step();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
